// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath: sequences fetch/decode/execute/
// memory/write-back, stalls on mem_ready_i and decodes all datapath selects from state and op.
module multicycle_ctrl #(
   parameter int ALU_OP_W = 3
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [5:0]          instr_op_i,
   input  logic                mem_ready_i,
   output logic                pc_write_o,
   output logic                pc_write_cond_o,
   output logic                iord_o,
   output logic                mem_read_o,
   output logic                mem_write_o,
   output logic                ir_write_o,
   output logic                reg_dst_o,
   output logic                mem_to_reg_o,
   output logic                reg_write_o,
   output logic                alu_src_a_o,
   output logic [1:0]          alu_src_b_o,
   output logic [ALU_OP_W-1:0] alu_op_o,
   output logic [1:0]          pc_src_o,
   output logic                se_o,
   output logic                illegal_o,
   output logic                retire_o,
   output logic [3:0]          state_o
);

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALU_FUNCT = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_ADD   = 3'b010;
   localparam logic [2:0] ALU_LUI   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;
   localparam logic [2:0] ALU_SLTU  = 3'b101;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXE    = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_I_EXE    = 4'd9,
      S_I_WB     = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   state_t     state_q;
   logic [5:0] op_q;
   logic [2:0] alu_class;

   // Unknown opcodes fall back to FETCH, so DECODE acts as a nop for them.
   function automatic state_t decode_next(input logic [5:0] op);
      case (op)
         OP_LW, OP_SW:                       return S_MEM_ADDR;
         OP_R:                               return S_R_EXE;
         OP_BEQ:                             return S_BRANCH;
         OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI: return S_I_EXE;
         OP_J:                               return S_JUMP;
         default:                            return S_FETCH;
      endcase
   endfunction

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= S_FETCH;
         op_q    <= '0;
      end else begin
         case (state_q)
            S_FETCH:    if (mem_ready_i) state_q <= S_DECODE;
            S_DECODE: begin
               op_q    <= instr_op_i;
               state_q <= decode_next(instr_op_i);
            end
            S_MEM_ADDR: state_q <= (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready_i) state_q <= S_MEM_WB;
            S_MEM_WR:   if (mem_ready_i) state_q <= S_FETCH;
            S_R_EXE:    state_q <= S_R_WB;
            S_I_EXE:    state_q <= S_I_WB;
            default:    state_q <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      iord_o          = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      reg_dst_o       = 1'b0;
      mem_to_reg_o    = 1'b0;
      reg_write_o     = 1'b0;
      alu_src_a_o     = 1'b0;
      alu_src_b_o     = 2'b00;
      alu_class       = ALU_FUNCT;
      pc_src_o        = 2'b00;
      se_o            = 1'b0;
      illegal_o       = 1'b0;
      retire_o        = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = 2'b01;
            alu_class   = ALU_ADD;
            ir_write_o  = mem_ready_i;
            pc_write_o  = mem_ready_i;
         end
         S_DECODE: begin
            alu_src_b_o = 2'b11;
            alu_class   = ALU_ADD;
            se_o        = 1'b1;
            illegal_o   = (decode_next(instr_op_i) == S_FETCH);
            retire_o    = (decode_next(instr_op_i) == S_FETCH);
         end
         S_MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            alu_class   = ALU_ADD;
            se_o        = 1'b1;
         end
         S_MEM_RD: begin
            mem_read_o = 1'b1;
            iord_o     = 1'b1;
         end
         S_MEM_WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 1'b1;
            retire_o     = 1'b1;
         end
         S_MEM_WR: begin
            mem_write_o = 1'b1;
            iord_o      = 1'b1;
            retire_o    = mem_ready_i;
         end
         S_R_EXE: alu_src_a_o = 1'b1;
         S_R_WB: begin
            reg_write_o = 1'b1;
            reg_dst_o   = 1'b1;
            retire_o    = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a_o     = 1'b1;
            alu_class       = ALU_SUB;
            pc_write_cond_o = 1'b1;
            pc_src_o        = 2'b01;
            se_o            = 1'b1;
            retire_o        = 1'b1;
         end
         S_I_EXE, S_I_WB: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            case (op_q)
               OP_SLTIU: begin alu_class = ALU_SLTU; se_o = 1'b1; end
               OP_LUI:   begin alu_class = ALU_LUI;  se_o = 1'b0; end
               OP_ORI:   begin alu_class = ALU_OR;   se_o = 1'b0; end
               default:  begin alu_class = ALU_ADD;  se_o = 1'b1; end
            endcase
            reg_write_o = (state_q == S_I_WB);
            retire_o    = (state_q == S_I_WB);
         end
         S_JUMP: begin
            pc_write_o = 1'b1;
            pc_src_o   = 2'b10;
            retire_o   = 1'b1;
         end
         default: ;
      endcase
      // Strobes are suppressed for as long as reset is held, not just at the edge.
      if (!rst_i) begin
         pc_write_o      = 1'b0;
         pc_write_cond_o = 1'b0;
         mem_read_o      = 1'b0;
         mem_write_o     = 1'b0;
         ir_write_o      = 1'b0;
         reg_write_o     = 1'b0;
         retire_o        = 1'b0;
         illegal_o       = 1'b0;
      end
   end

   assign alu_op_o = ALU_OP_W'(alu_class);
   assign state_o  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: one vector per clock cycle with expected state and
// a packed word of all control outputs, plus hand-written stall and reset sequences.
module tb_multicycle_ctrl;

   localparam logic [5:0] OP_R     = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BAD   = 6'b111111;

   // Packed order: pw pwc iord mr mw irw _ rdst m2r rw asa _ asb _ aop _ psrc _ se ill ret
   localparam logic [19:0] P_RST    = 20'b000000_0000_01_010_00_000;
   localparam logic [19:0] P_F1     = 20'b100101_0000_01_010_00_000;
   localparam logic [19:0] P_F0     = 20'b000100_0000_01_010_00_000;
   localparam logic [19:0] P_DEC    = 20'b000000_0000_11_010_00_100;
   localparam logic [19:0] P_DILL   = 20'b000000_0000_11_010_00_111;
   localparam logic [19:0] P_MADDR  = 20'b000000_0001_10_010_00_100;
   localparam logic [19:0] P_MRD    = 20'b001100_0000_00_000_00_000;
   localparam logic [19:0] P_MWB    = 20'b000000_0110_00_000_00_001;
   localparam logic [19:0] P_MWR1   = 20'b001010_0000_00_000_00_001;
   localparam logic [19:0] P_MWR0   = 20'b001010_0000_00_000_00_000;
   localparam logic [19:0] P_MWRR   = 20'b001000_0000_00_000_00_000;
   localparam logic [19:0] P_REXE   = 20'b000000_0001_00_000_00_000;
   localparam logic [19:0] P_RWB    = 20'b000000_1010_00_000_00_001;
   localparam logic [19:0] P_BR     = 20'b010000_0001_00_001_01_101;
   localparam logic [19:0] P_JMP    = 20'b100000_0000_00_000_10_001;
   localparam logic [19:0] P_ADDI_E = 20'b000000_0001_10_010_00_100;
   localparam logic [19:0] P_ADDI_W = 20'b000000_0011_10_010_00_101;
   localparam logic [19:0] P_ORI_E  = 20'b000000_0001_10_100_00_000;
   localparam logic [19:0] P_ORI_W  = 20'b000000_0011_10_100_00_001;
   localparam logic [19:0] P_SLT_E  = 20'b000000_0001_10_101_00_100;
   localparam logic [19:0] P_SLT_W  = 20'b000000_0011_10_101_00_101;
   localparam logic [19:0] P_LUI_E  = 20'b000000_0001_10_011_00_000;
   localparam logic [19:0] P_LUI_W  = 20'b000000_0011_10_011_00_001;

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic       rdy;
      logic [3:0] st;
      logic [19:0] ctrl;
   } vec_t;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic [5:0] instr_op_i = 6'd0;
   logic       mem_ready_i = 1'b1;
   logic       pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o;
   logic       reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, se_o, illegal_o, retire_o;
   logic [1:0] alu_src_b_o, pc_src_o;
   logic [3:0] alu_op_o;
   logic [3:0] state_o;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_no   = 0;
   vec_t tbl[31];

   always #5 clk_i = ~clk_i;

   multicycle_ctrl #(.ALU_OP_W(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
      .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .iord_o(iord_o),
      .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
      .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
      .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
      .pc_src_o(pc_src_o), .se_o(se_o), .illegal_o(illegal_o), .retire_o(retire_o),
      .state_o(state_o)
   );

   // One clock cycle: apply inputs just after the edge, then compare the settled outputs.
   task automatic cyc(input logic r, input logic [5:0] op, input logic rdy,
                      input logic [3:0] est, input logic [19:0] ectrl, input string nm);
      logic [19:0] act;
      @(posedge clk_i);
      #1;
      rst_i = r; instr_op_i = op; mem_ready_i = rdy;
      #1;
      act = {pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o, ir_write_o,
             reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o[2:0],
             pc_src_o, se_o, illegal_o, retire_o};
      $display("cycle %0d %s: rst=%b op=%b rdy=%b state=%0d ctrl=%b", cyc_no, nm, r, op, rdy,
               state_o, act);
      n_checks++;
      if (state_o !== est) begin
         n_fail++;
         $display("FAIL %s state: got %0d expected %0d", nm, state_o, est);
      end
      n_checks++;
      if (act !== ectrl) begin
         n_fail++;
         $display("FAIL %s ctrl: got %b expected %b", nm, act, ectrl);
      end
      n_checks++;
      if (alu_op_o[3] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s alu_op_hi: got %b expected 0", nm, alu_op_o[3]);
      end
      cyc_no++;
   endtask

   initial begin
      tbl[0]  = '{1'b0, OP_R,     1'b1, 4'd0,  P_RST};
      tbl[1]  = '{1'b0, OP_R,     1'b1, 4'd0,  P_RST};
      tbl[2]  = '{1'b1, OP_R,     1'b1, 4'd0,  P_F1};
      tbl[3]  = '{1'b1, OP_R,     1'b1, 4'd1,  P_DEC};
      tbl[4]  = '{1'b1, OP_ADDI,  1'b1, 4'd6,  P_REXE};
      tbl[5]  = '{1'b1, OP_ADDI,  1'b1, 4'd7,  P_RWB};
      tbl[6]  = '{1'b1, OP_ADDI,  1'b1, 4'd0,  P_F1};
      tbl[7]  = '{1'b1, OP_ADDI,  1'b1, 4'd1,  P_DEC};
      tbl[8]  = '{1'b1, OP_ORI,   1'b1, 4'd9,  P_ADDI_E};
      tbl[9]  = '{1'b1, OP_ORI,   1'b1, 4'd10, P_ADDI_W};
      tbl[10] = '{1'b1, OP_ORI,   1'b1, 4'd0,  P_F1};
      tbl[11] = '{1'b1, OP_ORI,   1'b1, 4'd1,  P_DEC};
      tbl[12] = '{1'b1, OP_SLTIU, 1'b1, 4'd9,  P_ORI_E};
      tbl[13] = '{1'b1, OP_SLTIU, 1'b1, 4'd10, P_ORI_W};
      tbl[14] = '{1'b1, OP_SLTIU, 1'b1, 4'd0,  P_F1};
      tbl[15] = '{1'b1, OP_SLTIU, 1'b1, 4'd1,  P_DEC};
      tbl[16] = '{1'b1, OP_LUI,   1'b1, 4'd9,  P_SLT_E};
      tbl[17] = '{1'b1, OP_LUI,   1'b1, 4'd10, P_SLT_W};
      tbl[18] = '{1'b1, OP_LUI,   1'b1, 4'd0,  P_F1};
      tbl[19] = '{1'b1, OP_LUI,   1'b1, 4'd1,  P_DEC};
      tbl[20] = '{1'b1, OP_BEQ,   1'b1, 4'd9,  P_LUI_E};
      tbl[21] = '{1'b1, OP_BEQ,   1'b1, 4'd10, P_LUI_W};
      tbl[22] = '{1'b1, OP_BEQ,   1'b1, 4'd0,  P_F1};
      tbl[23] = '{1'b1, OP_BEQ,   1'b1, 4'd1,  P_DEC};
      tbl[24] = '{1'b1, OP_J,     1'b1, 4'd8,  P_BR};
      tbl[25] = '{1'b1, OP_J,     1'b1, 4'd0,  P_F1};
      tbl[26] = '{1'b1, OP_J,     1'b1, 4'd1,  P_DEC};
      tbl[27] = '{1'b1, OP_BAD,   1'b1, 4'd11, P_JMP};
      tbl[28] = '{1'b1, OP_BAD,   1'b1, 4'd0,  P_F1};
      tbl[29] = '{1'b1, OP_BAD,   1'b1, 4'd1,  P_DILL};
      tbl[30] = '{1'b1, OP_LW,    1'b0, 4'd0,  P_F0};

      for (int i = 0; i < 31; i++)
         cyc(tbl[i].rst, tbl[i].op, tbl[i].rdy, tbl[i].st, tbl[i].ctrl, $sformatf("vec%0d", i));

      // lw with three stalled MEM_RD cycles; opcode changes after DECODE must be ignored
      cyc(1'b1, OP_LW, 1'b1, 4'd0, P_F1,    "lw_fetch");
      cyc(1'b1, OP_LW, 1'b1, 4'd1, P_DEC,   "lw_decode");
      cyc(1'b1, OP_SW, 1'b1, 4'd2, P_MADDR, "lw_addr");
      cyc(1'b1, OP_SW, 1'b0, 4'd3, P_MRD,   "lw_stall1");
      cyc(1'b1, OP_SW, 1'b0, 4'd3, P_MRD,   "lw_stall2");
      cyc(1'b1, OP_SW, 1'b0, 4'd3, P_MRD,   "lw_stall3");
      cyc(1'b1, OP_SW, 1'b1, 4'd3, P_MRD,   "lw_rd");
      cyc(1'b1, OP_SW, 1'b1, 4'd4, P_MWB,   "lw_wb");

      // sw with one stalled MEM_WR cycle
      cyc(1'b1, OP_SW, 1'b1, 4'd0, P_F1,    "sw_fetch");
      cyc(1'b1, OP_SW, 1'b1, 4'd1, P_DEC,   "sw_decode");
      cyc(1'b1, OP_SW, 1'b1, 4'd2, P_MADDR, "sw_addr");
      cyc(1'b1, OP_SW, 1'b0, 4'd5, P_MWR0,  "sw_stall");
      cyc(1'b1, OP_SW, 1'b1, 4'd5, P_MWR1,  "sw_wr");

      // reset asserted in the middle of a MEM_WR stall
      cyc(1'b1, OP_SW, 1'b1, 4'd0, P_F1,    "rsw_fetch");
      cyc(1'b1, OP_SW, 1'b1, 4'd1, P_DEC,   "rsw_decode");
      cyc(1'b1, OP_SW, 1'b1, 4'd2, P_MADDR, "rsw_addr");
      cyc(1'b1, OP_SW, 1'b0, 4'd5, P_MWR0,  "rsw_stall");
      cyc(1'b0, OP_SW, 1'b0, 4'd5, P_MWRR,  "rsw_reset");
      cyc(1'b1, OP_SW, 1'b0, 4'd0, P_F0,    "rsw_after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multi-cycle control unit for the MIPS-subset datapath; successor to the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states. It stalls on a memory-ready handshake and drives all datapath selects and write strobes, including ALU op class and sign/zero-extend select. It sits between the instruction register and the shared-memory multi-cycle datapath.

## Interface

Parameters:
- ALU_OP_W, 3, width of alu_op_o; must be ≥3; bits above [2:0] always 0.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- instr_op_i  in  6  opcode field of the instruction register; sampled in DECODE.
- mem_ready_i  in  1  memory completes the current read/write this cycle.
- pc_write_o  out  1  unconditional PC load.
- pc_write_cond_o  out  1  PC load qualified by ALU zero (beq).
- iord_o  out  1  memory address: 0=PC, 1=ALUOut.
- mem_read_o / mem_write_o  out  1 each  memory strobes.
- ir_write_o  out  1  instruction register load.
- reg_dst_o  out  1  1=rd, 0=rt.
- mem_to_reg_o  out  1  1=MDR, 0=ALUOut.
- reg_write_o  out  1  register file write.
- alu_src_a_o  out  1  0=PC, 1=rs.
- alu_src_b_o  out  2  00=rt, 01=4, 10=ext imm, 11=ext imm<<2.
- alu_op_o  out  ALU_OP_W  000 R-type(funct), 001 sub, 010 add, 011 lui, 100 or, 101 sltu.
- pc_src_o  out  2  00=ALU, 01=ALUOut, 10=jump target.
- se_o  out  1  1=sign-extend immediate, 0=zero-extend.
- illegal_o  out  1  unknown opcode seen in DECODE.
- retire_o  out  1  instruction completes this cycle.
- state_o  out  4  current state, for debug.

## Operation

- Opcodes: R 000000, addi 001000, sltiu 001011, beq 000100, lui 001111, ori 001101, lw 100011, sw 101011, j 000010.
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXE 6, R_WB 7, BRANCH 8, I_EXE 9, I_WB 10, JUMP 11; codes 12–15 unreachable and return to FETCH.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00.
  - ir_write and pc_write equal mem_ready_i.
  - Advances to DECODE only when mem_ready_i=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=add, se=1.
  - Latches instr_op_i into op_q.
  - Next state: lw/sw→MEM_ADDR, R→R_EXE, beq→BRANCH, addi/sltiu/lui/ori→I_EXE, j→JUMP.
  - Unknown opcode: illegal_o=1 and retire_o=1; next state is FETCH (treated as nop).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add, se=1; lw→MEM_RD, sw→MEM_WR.
- MEM_RD:
  - mem_read=1, iord=1.
  - Holds until mem_ready_i, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1; next state FETCH.
- MEM_WR:
  - mem_write=1, iord=1.
  - Holds until mem_ready_i; retire=mem_ready_i; then FETCH.
- R_EXE: alu_src_a=1, alu_src_b=00, alu_op=000. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_write_cond=1, pc_src=01, se=1, retire=1.
- I_EXE:
  - alu_src_a=1, alu_src_b=10.
  - alu_op: addi→add, sltiu→sltu, lui→lui, ori→or.
  - se: addi/sltiu=1, ori/lui=0.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, retire=1; I_EXE outputs held.
- JUMP: pc_write=1, pc_src=10, retire=1.
- Any output not listed for a state is 0.

## Timing

- Moore outputs, decoded from state_q and op_q. Exceptions:
  - FETCH ir_write/pc_write and MEM_WR retire gate on mem_ready_i.
  - DECODE illegal_o/retire_o depend on instr_op_i.
- Cycles per instruction with mem_ready_i held 1: R/I-type 4, lw 5, sw 4, beq 3, j 3, illegal 2.
- Each low cycle of mem_ready_i in FETCH, MEM_RD or MEM_WR adds one cycle. All outputs are stable while stalled; strobes stay asserted.
- Reset:
  - rst_i=0 at an edge sets state_q=FETCH and op_q=0, regardless of current state, including mid-stall.
  - While rst_i=0, all strobes (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, retire, illegal) are forced 0.
  - First fetch begins in the cycle after rst_i returns to 1.
- op_q changes only in DECODE. A change on instr_op_i in any other state has no effect.

## Test plan

- Reset with rst_i=0 for 2 cycles, then release with mem_ready_i=1: state_o=0 during reset and all strobes 0. Cycle after release: mem_read_o=1, ir_write_o=1, pc_write_o=1.
- R-type 000000 then addi 001000, ready=1: state sequence 0,1,6,7,0,1,9,10. retire_o high only in states 7 and 10. alu_op_o=000, then 010 with se_o=1.
- lw 100011 with mem_ready_i low for 3 cycles in MEM_RD: 8 cycles total. mem_read_o=1, iord_o=1 held throughout. reg_write_o=1, mem_to_reg_o=1 only in MEM_WB.
- ori 001101, then sltiu 001011, then lui 001111: in I_EXE, alu_op_o/se_o = 100/0, then 101/1, then 011/0.
- beq 000100 and j 000010: beq gives pc_write_cond_o=1, pc_src_o=01, alu_op_o=001 in state 8. j gives pc_write_o=1, pc_src_o=10 in state 11; 3 cycles each.
- Opcode 111111: illegal_o=1 in DECODE, FETCH next, no reg_write/mem_write asserted. Separately, rst_i=0 mid-MEM_WR stall: FETCH next cycle and mem_write_o=0.
